dnn_weight_scheduler: RTL and testbench
=======================================

DNN_WEIGHT_SCHEDULER -- requirements
Module: dnn_weight_scheduler

Interface
REQ-001 Parameters SHALL be:
- NumLayers, 4: systolic layers sequenced.
- MaxNumNerves, 6: weight lanes.
- M_W_BitSize, 16: bits per lane.
- ImageSize, 16: inputs of layer 0.
- LNN, '{2,3,5,6}: nerves per layer; LNN[k] is layer k, so LNN[0]=6.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  clock.
- res  in  1  reset.
- in_start  in  1  begin load.
- in_abort  in  1  cancel load.
- in_w_valid  in  1  source word valid.
- in_w_data  in  MaxNumNerves*M_W_BitSize  weight word.
- out_w_ready  out  1  word accept.
- out_weights  out  MaxNumNerves*M_W_BitSize  registered word.
- out_w_valid  out  1  out_weights valid.
- out_layer_en  out  NumLayers  one-hot destination of out_weights.
- out_layer_res_n  out  NumLayers  active-low per-layer clear.
- out_layer_idx  out  $clog2(NumLayers)  layer being loaded.
- out_busy  out  1  sequence running.
- out_done  out  1  all layers loaded.
- out_timeout  out  1  watchdog error.
REQ-003 One clock (clk); reset res is asynchronous, active-high.

Function
REQ-004 Rows(k) SHALL be ImageSize for k=0 and LNN[k-1] otherwise; layer k needs Rows(k) accepted words.
REQ-005 FSM states SHALL be IDLE, CLEAR, LOAD, DONE, ERR.
REQ-006 IDLE or DONE with in_start=1 SHALL go to CLEAR with layer=0, word=0, out_done=0.
REQ-007 CLEAR SHALL last exactly one cycle, drive out_layer_res_n[layer]=0 (all other bits 1), then enter LOAD.
REQ-008 out_w_ready SHALL be 1 only in LOAD; a word is accepted when in_w_valid && out_w_ready.
REQ-009 Each acceptance SHALL increment word; on Rows(layer)-th acceptance, word resets to 0 and the FSM goes to CLEAR for layer+1, or to DONE if layer==NumLayers-1.
REQ-010 in_w_valid=0 in LOAD SHALL hold all counters (stall, no timeout unless REQ-018).
REQ-011 Accepted words SHALL appear on out_weights one cycle later with out_w_valid=1 and out_layer_en=1<<layer; lanes at index >= LNN[layer] SHALL be zeroed.
REQ-012 out_busy SHALL be 1 in CLEAR and LOAD; out_done SHALL be 1 in DONE (sticky until in_start or in_abort).
REQ-013 in_start in CLEAR, LOAD or ERR SHALL be ignored.
REQ-014 in_abort SHALL win over in_start and in_w_valid: the next state is IDLE, the word in that cycle is not accepted, and out_done=0.
REQ-015 Continuous valid SHALL give sum over k of (1+Rows(k)) busy cycles; defaults give 34.

Reset
REQ-016 res=1 SHALL immediately force state IDLE, counters 0, out_w_ready=0, out_w_valid=0, out_weights=0, out_layer_en=0, out_layer_res_n all 1, out_layer_idx=0, out_busy=0, out_done=0, out_timeout=0.
REQ-017 Reset mid-LOAD SHALL discard progress; loading restarts only on a new in_start.

Configuration
REQ-018 With DNN_WSCHED_TIMEOUT_EN defined, TimeoutCycles (default 64) consecutive LOAD cycles with in_w_valid=0 SHALL enter ERR with out_timeout=1; ERR exits only via in_abort or res, and out_timeout clears on exit. Without the macro, out_timeout SHALL be tied 0 and ERR is unreachable.

Structure
REQ-019 Package dnn_sched_pkg SHALL hold the state enum typedef and a constant function rows(k, ImageSize, LNN).
REQ-020 One sub-module, dnn_wsched_watchdog (stall counter), SHALL be instantiated only under DNN_WSCHED_TIMEOUT_EN.

Verification
REQ-021 The bench SHALL cover these scenarios with default parameters:
- Start pulse, continuous valid: busy 34 cycles; out_layer_res_n pulses at layers 0,1,2,3 in cycles 1,18,25,31; out_done rises on cycle 35; 30 out_w_valid beats.
- Stall: valid low for 5 cycles at word 3 of layer 1: word count stays 3, completion is delayed by exactly 5 cycles.
- Lane mask: in_w_data all 0xFFFF during layer 3: lanes 0..1 are 0xFFFF, lanes 2..5 are 0.
- Abort at word 10 of layer 0: IDLE next cycle, out_done=0; a second in_start reloads from layer 0, word 0.
- Async res asserted mid-LOAD between clock edges: outputs reach reset values before the next edge.
- Macro on, TimeoutCycles=64, valid held low in LOAD: out_timeout=1 after 64 cycles; in_abort clears it.

Source files
------------

// File: rtl/dnn_sched_pkg.sv
// Shared state type and row-count helper for the DNN weight scheduler.
package dnn_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } sched_state_e;

    // Layer 0 is fed by the image; every later layer by its predecessor's nerves.
    function automatic int rows(input int k, input int image_size, input int lnn_prev);
        return (k == 0) ? image_size : lnn_prev;
    endfunction

endpackage

// File: rtl/dnn_wsched_watchdog.sv
// Counts consecutive stalled LOAD cycles and flags the TimeoutCycles-th one.
module dnn_wsched_watchdog #(
    parameter int TimeoutCycles = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic expired
);
    localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    logic [CntW-1:0] cnt;

    assign expired = stall && (cnt == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!stall || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dnn_weight_scheduler.sv
// Sequences weight words into NumLayers systolic layers, clearing each layer first.
// Define DNN_WSCHED_TIMEOUT_EN to enable the stalled-source watchdog and ERR state.
module dnn_weight_scheduler
    import dnn_sched_pkg::*;
#(
    parameter int NumLayers                 = 4,
    parameter int MaxNumNerves              = 6,
    parameter int M_W_BitSize               = 16,
    parameter int ImageSize                 = 16,
    parameter int LNN [NumLayers-1:0]       = '{2, 3, 5, 6}
`ifdef DNN_WSCHED_TIMEOUT_EN
    , parameter int TimeoutCycles           = 64
`endif
) (
    input  logic                                 clk,
    input  logic                                 res,
    input  logic                                 in_start,
    input  logic                                 in_abort,
    input  logic                                 in_w_valid,
    input  logic [MaxNumNerves*M_W_BitSize-1:0]  in_w_data,
    output logic                                 out_w_ready,
    output logic [MaxNumNerves*M_W_BitSize-1:0]  out_weights,
    output logic                                 out_w_valid,
    output logic [NumLayers-1:0]                 out_layer_en,
    output logic [NumLayers-1:0]                 out_layer_res_n,
    output logic [$clog2(NumLayers)-1:0]         out_layer_idx,
    output logic                                 out_busy,
    output logic                                 out_done,
    output logic                                 out_timeout
);
    localparam int DataW   = MaxNumNerves * M_W_BitSize;
    localparam int LayW    = $clog2(NumLayers);
    localparam int MaxRows = (ImageSize > MaxNumNerves) ? ImageSize : MaxNumNerves;
    localparam int WordW   = $clog2(MaxRows + 1);
    localparam logic [NumLayers-1:0] LayerOne = {{(NumLayers-1){1'b0}}, 1'b1};

    sched_state_e       state;
    logic [LayW-1:0]    layer;
    logic [WordW-1:0]   word;
    logic [DataW-1:0]   masked_data;
    logic               timeout_hit;
    logic               stall;

    logic [WordW-1:0]        rows_tbl  [NumLayers];
    logic [MaxNumNerves-1:0] lane_keep [NumLayers];

    for (genvar k = 0; k < NumLayers; k++) begin : g_tbl
        localparam int Prev = (k == 0) ? 0 : LNN[(k == 0) ? 0 : k - 1];
        assign rows_tbl[k] = WordW'(rows(k, ImageSize, Prev));
        for (genvar l = 0; l < MaxNumNerves; l++) begin : g_lane
            assign lane_keep[k][l] = (l < LNN[k]);
        end
    end

    always_comb begin
        masked_data = '0;
        for (int unsigned l = 0; l < MaxNumNerves; l++) begin
            if (lane_keep[layer][l]) begin
                masked_data[l*M_W_BitSize +: M_W_BitSize] = in_w_data[l*M_W_BitSize +: M_W_BitSize];
            end
        end
    end

    assign stall = (state == ST_LOAD) && !in_w_valid && !in_abort;

`ifdef DNN_WSCHED_TIMEOUT_EN
    dnn_wsched_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_watchdog (
        .clk     (clk),
        .rst     (res),
        .stall   (stall),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign out_layer_idx = layer;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state           <= ST_IDLE;
            layer           <= '0;
            word            <= '0;
            out_w_ready     <= 1'b0;
            out_weights     <= '0;
            out_w_valid     <= 1'b0;
            out_layer_en    <= '0;
            out_layer_res_n <= '1;
            out_busy        <= 1'b0;
            out_done        <= 1'b0;
            out_timeout     <= 1'b0;
        end else begin
            out_w_valid     <= 1'b0;
            out_layer_en    <= '0;
            out_layer_res_n <= '1;
            if (in_abort) begin
                state       <= ST_IDLE;
                layer       <= '0;
                word        <= '0;
                out_w_ready <= 1'b0;
                out_busy    <= 1'b0;
                out_done    <= 1'b0;
                out_timeout <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE, ST_DONE: begin
                        if (in_start) begin
                            state           <= ST_CLEAR;
                            layer           <= '0;
                            word            <= '0;
                            out_done        <= 1'b0;
                            out_busy        <= 1'b1;
                            out_layer_res_n <= ~LayerOne;
                        end
                    end
                    ST_CLEAR: begin
                        state       <= ST_LOAD;
                        out_w_ready <= 1'b1;
                    end
                    ST_LOAD: begin
                        if (in_w_valid) begin
                            out_weights  <= masked_data;
                            out_w_valid  <= 1'b1;
                            out_layer_en <= LayerOne << layer;
                            if (word == rows_tbl[layer] - 1'b1) begin
                                word        <= '0;
                                out_w_ready <= 1'b0;
                                if (layer == LayW'(NumLayers - 1)) begin
                                    state    <= ST_DONE;
                                    out_busy <= 1'b0;
                                    out_done <= 1'b1;
                                end else begin
                                    state           <= ST_CLEAR;
                                    layer           <= layer + 1'b1;
                                    out_layer_res_n <= ~(LayerOne << (layer + 1'b1));
                                end
                            end else begin
                                word <= word + 1'b1;
                            end
                        end else if (timeout_hit) begin
                            state       <= ST_ERR;
                            out_w_ready <= 1'b0;
                            out_busy    <= 1'b0;
                            out_timeout <= 1'b1;
                        end
                    end
                    ST_ERR: begin
                        state <= ST_ERR;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dnn_weight_scheduler.sv
// Scoreboard bench for dnn_weight_scheduler against a load-plan reference model.
module tb_dnn_weight_scheduler;
    localparam int NL = 4;
    localparam int NN = 6;
    localparam int BW = 16;
    localparam int DW = NN * BW;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          in_start = 1'b0;
    logic          in_abort = 1'b0;
    logic          in_w_valid = 1'b0;
    logic [DW-1:0] in_w_data = '0;
    logic          out_w_ready;
    logic [DW-1:0] out_weights;
    logic          out_w_valid;
    logic [NL-1:0] out_layer_en;
    logic [NL-1:0] out_layer_res_n;
    logic [1:0]    out_layer_idx;
    logic          out_busy;
    logic          out_done;
    logic          out_timeout;

    dnn_weight_scheduler dut (
        .clk             (clk),
        .res             (res),
        .in_start        (in_start),
        .in_abort        (in_abort),
        .in_w_valid      (in_w_valid),
        .in_w_data       (in_w_data),
        .out_w_ready     (out_w_ready),
        .out_weights     (out_weights),
        .out_w_valid     (out_w_valid),
        .out_layer_en    (out_layer_en),
        .out_layer_res_n (out_layer_res_n),
        .out_layer_idx   (out_layer_idx),
        .out_busy        (out_busy),
        .out_done        (out_done),
        .out_timeout     (out_timeout)
    );

    always #5 clk = ~clk;

    // Reference: nerves per layer (index = layer) and the resulting load plan.
    int lnn [NL] = '{6, 5, 3, 2};

    typedef struct {
        bit is_word;
        int layer;
        int word;
    } tok_t;

    typedef struct {
        int            layer;
        logic [DW-1:0] data;
    } beat_t;

    tok_t  plan [$];
    beat_t sb   [$];
    bit    m_done, m_err;
    int    m_idx, m_stall;

    int    checks = 0;
    int    errors = 0;
    int    edge_n = 0;
    bit    mon_en = 0;

    int    start_edge, busy_cnt, done_cyc, beat_cnt;
    int    pulse_cyc [NL];

    function automatic int rows_of(input int k);
        return (k == 0) ? 16 : lnn[k-1];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        plan.delete();
        sb.delete();
        m_done  = 0;
        m_err   = 0;
        m_idx   = 0;
        m_stall = 0;
    endtask

    task automatic model_edge(input bit st, input bit ab, input bit v, input logic [DW-1:0] d);
        beat_t b;
        if (ab) begin
            plan.delete();
            m_done = 0; m_err = 0; m_idx = 0; m_stall = 0;
        end else if (m_err) begin
            m_err = 1;
        end else if (plan.size() == 0) begin
            if (st) begin
                for (int k = 0; k < NL; k++) begin
                    plan.push_back('{0, k, 0});
                    for (int w = 0; w < rows_of(k); w++) plan.push_back('{1, k, w});
                end
                m_done = 0; m_idx = 0; m_stall = 0;
            end
        end else if (!plan[0].is_word) begin
            void'(plan.pop_front());
            m_stall = 0;
        end else if (v) begin
            b.layer = plan[0].layer;
            b.data  = '0;
            for (int l = 0; l < NN; l++)
                if (l < lnn[b.layer]) b.data[l*BW +: BW] = d[l*BW +: BW];
            sb.push_back(b);
            void'(plan.pop_front());
            m_stall = 0;
            if (plan.size() == 0) m_done = 1;
        end else begin
`ifdef DNN_WSCHED_TIMEOUT_EN
            m_stall++;
            if (m_stall == TIMEOUT) begin
                m_err = 1;
                plan.delete();
            end
`endif
        end
        if (plan.size() > 0) m_idx = plan[0].layer;
    endtask

    function automatic logic [9:0] exp_flags();
        logic [NL-1:0] rn;
        rn = '1;
        if (plan.size() > 0 && !plan[0].is_word) rn[plan[0].layer] = 1'b0;
        return {plan.size() > 0 && plan[0].is_word, plan.size() > 0, rn, 2'(m_idx), m_done, m_err};
    endfunction

    // Monitor: compares control flags every cycle and pops the scoreboard on each beat.
    always @(negedge clk) begin
        beat_t b;
        if (mon_en && !res) begin
            chk("flags", {out_w_ready, out_busy, out_layer_res_n, out_layer_idx, out_done, out_timeout},
                exp_flags());
            if (out_w_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = sb.pop_front();
                    chk("beat_data", out_weights, b.data);
                    chk("beat_en", out_layer_en, 4'b0001 << b.layer);
                end
            end
        end
    end

    task automatic step(input bit st, input bit ab, input bit v, input logic [DW-1:0] d);
        in_start = st; in_abort = ab; in_w_valid = v; in_w_data = d;
        @(posedge clk);
        edge_n++;
        model_edge(st, ab, v, d);
        #1;
        in_start = 0; in_abort = 0; in_w_valid = 0;
    endtask

    task automatic measure();
        int c;
        c = edge_n - start_edge + 1;
        if (out_busy) busy_cnt++;
        if (out_w_valid) beat_cnt++;
        for (int k = 0; k < NL; k++)
            if (!out_layer_res_n[k] && pulse_cyc[k] < 0) pulse_cyc[k] = c;
        if (out_done && done_cyc < 0) done_cyc = c;
    endtask

    task automatic run_load(input int stall_k, input int stall_w, input int stall_n);
        int left;
        bit v;
        logic [DW-1:0] d;
        left = stall_n;
        busy_cnt = 0; done_cyc = -1; beat_cnt = 0;
        for (int k = 0; k < NL; k++) pulse_cyc[k] = -1;
        step(1, 0, 0, '0);
        start_edge = edge_n;
        measure();
        for (int n = 0; n < 200 && done_cyc < 0; n++) begin
            v = 1;
            if (plan.size() > 0 && plan[0].is_word && plan[0].layer == stall_k &&
                plan[0].word == stall_w && left > 0) begin
                v = 0;
                left--;
            end
            d = (plan.size() > 0 && plan[0].layer == 3) ? '1 : rand96();
            step(0, 0, v, d);
            measure();
        end
        if (done_cyc < 0) chk("done_wait_expired", 0, 1);
    endtask

    task automatic advance_to(input int k, input int w);
        for (int n = 0; n < 100; n++) begin
            if (plan.size() > 0 && plan[0].is_word && plan[0].layer == k && plan[0].word == w) return;
            step(0, 0, 1, rand96());
        end
        chk("advance_wait_expired", 0, 1);
    endtask

    initial begin
        int exp_p [NL] = '{1, 18, 25, 31};
        logic [DW-1:0] lane_exp;
        int r;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", out_w_ready, 0);
        chk("rst_valid", out_w_valid, 0);
        chk("rst_weights", out_weights, 0);
        chk("rst_en", out_layer_en, 0);
        chk("rst_res_n", out_layer_res_n, 4'hF);
        chk("rst_misc", {out_layer_idx, out_busy, out_done, out_timeout}, 0);
        res = 0;
        mon_en = 1;

        // Continuous valid, layer 3 fed all-ones to exercise the lane mask.
        run_load(-1, 0, 0);
        chk("busy_cycles", busy_cnt, 34);
        for (int k = 0; k < NL; k++) chk("res_n_pulse_cycle", pulse_cyc[k], exp_p[k]);
        chk("done_cycle", done_cyc, 35);
        chk("beats", beat_cnt, 30);
        lane_exp = '0;
        lane_exp[2*BW-1:0] = '1;
        chk("lane_mask", out_weights, lane_exp);
        step(0, 0, 0, '0);
        chk("done_sticky", out_done, 1);
        step(0, 1, 0, '0);
        chk("abort_clears_done", out_done, 0);

        // Five stall cycles at word 3 of layer 1.
        run_load(1, 3, 5);
        chk("stall_done_cycle", done_cyc, 40);
        chk("stall_busy_cycles", busy_cnt, 39);
        chk("stall_beats", beat_cnt, 30);

        // Abort at word 10 of layer 0, then reload from scratch.
        step(1, 0, 0, '0);
        advance_to(0, 10);
        step(0, 1, 1, rand96());
        chk("abort_busy", out_busy, 0);
        chk("abort_done", out_done, 0);
        chk("abort_ready", out_w_ready, 0);
        run_load(-1, 0, 0);
        chk("reload_done_cycle", done_cyc, 35);
        chk("reload_beats", beat_cnt, 30);

        // Asynchronous reset between edges in the middle of layer 1.
        step(1, 0, 0, '0);
        advance_to(1, 5);
        in_w_valid = 1;
        in_w_data  = rand96();
        #2;
        res = 1;
        #1;
        chk("async_rst_outputs",
            {out_w_ready, out_w_valid, out_busy, out_done, out_timeout, out_layer_idx, out_layer_en, out_layer_res_n},
            {5'b0, 2'b0, 4'h0, 4'hF});
        chk("async_rst_weights", out_weights, 0);
        model_reset();
        @(posedge clk);
        #1;
        res = 0;
        in_w_valid = 0;
        for (int n = 0; n < 3; n++) step(0, 0, 1, rand96());
        chk("no_restart_without_start", out_busy, 0);
        run_load(-1, 0, 0);
        chk("post_rst_done_cycle", done_cyc, 35);

`ifdef DNN_WSCHED_TIMEOUT_EN
        begin
            int tcyc;
            tcyc = -1;
            step(1, 0, 0, '0);
            step(0, 0, 0, '0);
            for (int n = 0; n < 100 && tcyc < 0; n++) begin
                step(0, 0, 0, '0);
                if (out_timeout) tcyc = n + 1;
            end
            chk("timeout_cycles", tcyc, TIMEOUT);
            step(1, 0, 1, rand96());
            chk("err_holds", {out_timeout, out_busy}, 2'b10);
            step(0, 1, 0, '0);
            chk("abort_clears_timeout", {out_timeout, out_busy, out_done}, 3'b000);
        end
`endif

        // Randomized traffic with stray starts and aborts.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            step(r < 5, (r >= 5 && r < 7), $urandom_range(0, 99) < 70, rand96());
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end
endmodule
